// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-timing tick constants and default frame shape.
// Used by uart_rx and uart_tx so that both ends agree on DBIT/SB_TICK defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int MID_TICK    = 7;
  localparam int LAST_TICK   = 15;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  // Bits needed to hold maxval, never less than one.
  function automatic int cnt_width(input int maxval);
    int w;
    w = $clog2(maxval + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; RST_VAL sets the value both flops take in reset.
// Latency two clk; no flow control.
module sync_2ff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver on a 16x s_tick: synchronised rx, start-bit validation, LSB-first data, stop check, one-clk done strobe.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined (PARITY_ODD selects the sense).
module uart_rx
  import uart_pkg::*;
#(
`ifdef UART_RX_PARITY_EN
  parameter bit PARITY_ODD = 1'b0,
`endif
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  // s must hold both LAST_TICK and SB_TICK-1 (1.5 / 2 stop bits need more than 4 bits).
  localparam int SW = (cnt_width(SB_TICK - 1) > 4) ? cnt_width(SB_TICK - 1) : 4;
  localparam int NW = cnt_width(DBIT - 1);

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(LAST_TICK);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_s;

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  sync_2ff #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  // par_q holds the parity verdict until the stop bit publishes it with the strobe.
  logic par_q, par_d;
  logic perr_q, perr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    case (state_q)
      // Falling edge is taken immediately, without waiting for a tick.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            par_d   = ((^b_q) ^ rx_s) != PARITY_ODD;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the counterpart of the existing uart_tx; shares the baud_rate_generator 16x oversampling tick (s_tick).
- Synchronises the asynchronous rx line, then detects and validates the start bit.
- Samples DBIT data bits LSB-first at bit centres, checks the stop bit and presents the byte with a one-cycle done strobe.
- Sits between the board RX pin and the UART interface/FIFO logic.

Parameters:
DBIT, 8, number of data bits per frame
SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd)

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset
s_tick  input  1  16x baud enable pulse, one clk wide, from baud_rate_generator
rx  input  1  serial line, asynchronous, idle high
dout  output  DBIT  last received data word
rx_done_tick  output  1  one-clk pulse: dout valid and updated
frame_err  output  1  stop bit sampled low on last frame
parity_err  output  1  parity mismatch on last frame (tied 0 without the macro)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE.
  - dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0, busy = 0.
  - Synchroniser flops = 1. Counters s and n = 0. Shift register b = 0.
- Input synchronisation: two-flop synchroniser on rx produces rx_s. All FSM decisions use rx_s only, giving 2 clk of latency from the rx pin.
- Counters: s (4 bits) counts s_tick; n (ceil(log2 DBIT) bits) counts data bits. Counters advance only on clk edges where s_tick = 1.
- IDLE:
  - rx_s == 0 → START, s = 0. This edge detection does not wait for s_tick.
- START:
  - On s_tick with s == 7, rx_s is sampled at mid start bit.
    - rx_s == 0 → DATA, s = 0, n = 0.
    - rx_s == 1 → glitch; return to IDLE with no strobe and no flag change.
  - Otherwise s increments.
- DATA:
  - On s_tick with s == 15: s = 0 and b = {rx_s, b[DBIT-1:1]}.
  - If n == DBIT-1 → STOP (or PARITY with the macro); else n increments.
- STOP:
  - On s_tick with s == SB_TICK-1:
    - dout <= b.
    - frame_err <= ~rx_s.
    - rx_done_tick <= 1 for exactly one clk.
    - → IDLE.
  - For SB_TICK > 16, s widens to hold SB_TICK-1.
- Flags frame_err and parity_err hold until the next rx_done_tick overwrites them. A frame with a framing error still delivers dout and rx_done_tick.
- A low rx_s still present in IDLE immediately after STOP (back-to-back frame or break) starts a new frame. A continuous break produces a frame of all zeros with frame_err = 1 each frame.
- s_tick is ignored in IDLE. rx_done_tick never asserts twice within SB_TICK ticks.
- If reset is asserted mid-frame, everything clears immediately and the partial frame is discarded with no strobe.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, sampled on s_tick with s == 15.
  - parity_err <= (^b ^ rx_s) != PARITY_ODD, registered together with rx_done_tick.
- Undefined:
  - No PARITY state; parity_err is constant 0.
  - Frame format is 8N1-compatible, identical to uart_tx.

Decomposition:
- Package uart_pkg:
  - State encoding constants: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4.
  - Mid-bit sample constant 7 and last-tick constant 15.
  - Default DBIT and SB_TICK values, shared with uart_tx.
- One sub-module: sync_2ff, a generic two-flop synchroniser with a reset value parameter, instantiated here with reset value 1.

Test Plan:
- Loopback: uart_tx → uart_rx with shared baud_rate_generator (DIVISOR 651, bit period ~104.16 us); send 0x55, 0xAA, 0x00, 0xFF, 0xA5, 0x5A → each gives one rx_done_tick, dout equals the byte, frame_err = 0.
- Glitch: drive rx low for 3 bit-ticks (~19.5 us), then high → no rx_done_tick, busy returns to 0, dout unchanged.
- Framing error: hand-driven frame 0x3C with the stop bit forced to 0 → dout = 0x3C, frame_err = 1, one strobe; next clean frame 0x42 → frame_err = 0.
- Back-to-back: two frames 0x12, 0x34 with zero idle gap → two strobes about 10 bit periods apart, correct order, no lost byte.
- Reset mid-frame: assert reset during data bit 4 of 0xC3, release, send 0x7E → no strobe for 0xC3; dout = 0x7E.
- With UART_RX_PARITY_EN, even parity: 0x07 with parity bit 1 → parity_err = 0; same byte with parity bit 0 → parity_err = 1.
